// File: rtl/booth_pp_reduce_pipe.sv
// Pipelined 4:2 compressor tree that sums NPP partial products modulo 2^PP_W,
// one register stage per compressor level plus a registered final adder.
module booth_pp_reduce_pipe #(
   parameter int PP_W  = 128,
   parameter int NPP   = 8,
   parameter int TAG_W = 4
) (
   input  logic                clk,
   input  logic                rst_n,
   input  logic                in_valid,
   output logic                in_ready,
   input  logic [NPP*PP_W-1:0] in_pp,
   input  logic [TAG_W-1:0]    in_tag,
   output logic                out_valid,
   input  logic                out_ready,
   output logic [PP_W-1:0]     out_product,
   output logic [TAG_W-1:0]    out_tag
);

   localparam int LEVELS = $clog2(NPP) - 1;

   if (NPP != 4 && NPP != 8 && NPP != 16) begin : g_bad_npp
      $error("booth_pp_reduce_pipe: NPP must be 4, 8 or 16");
   end

   // Handshake: a stage loads whenever it is empty or its successor loads;
   // valid travels with the data, so in_ready never looks at in_valid.
   logic [LEVELS:0]    v;
   logic [LEVELS:0]    rdy;
   logic [LEVELS:0]    up_v;
   logic [TAG_W-1:0]   tag_q  [LEVELS+1];
   logic [TAG_W-1:0]   up_tag [LEVELS+1];
   logic [PP_W-1:0]    product_q;

   function automatic logic [2*PP_W-1:0] compress42(
      input logic [PP_W-1:0] a,
      input logic [PP_W-1:0] b,
      input logic [PP_W-1:0] c,
      input logic [PP_W-1:0] d
   );
      logic [PP_W-1:0] w;
      logic [PP_W-1:0] t;
      logic [PP_W-1:0] cin;
      logic [PP_W-1:0] cy;
      w   = a ^ b ^ c ^ d;
      t   = (a | b) & (c | d);
      cin = {t[PP_W-2:0], 1'b0};
      cy  = (w & cin) | (~w & ((a & b) | (c & d)));
      return {w ^ cin, cy[PP_W-2:0], 1'b0};
   endfunction

   always_comb begin : p_ready
      logic r;
      r = out_ready;
      for (int n = LEVELS; n >= 0; n--) begin
         r      = !v[n] || r;
         rdy[n] = r;
      end
   end

   assign up_v = {v[LEVELS-1:0], in_valid};

   always_comb begin
      up_tag[0] = in_tag;
      for (int n = 1; n <= LEVELS; n++) begin
         up_tag[n] = tag_q[n-1];
      end
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         v <= '0;
         for (int n = 0; n <= LEVELS; n++) begin
            tag_q[n] <= '0;
         end
      end else begin
         for (int n = 0; n <= LEVELS; n++) begin
            if (rdy[n]) begin
               v[n]     <= up_v[n];
               tag_q[n] <= up_tag[n];
            end
         end
      end
   end

   for (genvar j = 0; j < LEVELS; j++) begin : g_lvl
      localparam int NIN  = NPP >> j;
      localparam int NOUT = NIN / 2;

      logic [PP_W-1:0] src [NIN];
      logic [PP_W-1:0] nxt [NOUT];
      logic [PP_W-1:0] q   [NOUT];

      if (j == 0) begin : g_src_in
         always_comb begin
            for (int i = 0; i < NIN; i++) begin
               src[i] = in_pp[i*PP_W +: PP_W];
            end
         end
      end else begin : g_src_prev
         always_comb begin
            for (int i = 0; i < NIN; i++) begin
               src[i] = g_lvl[j-1].q[i];
            end
         end
      end

      // Cell m reduces vectors 4m..4m+3 into the (sum, carry) pair at 2m, 2m+1.
      always_comb begin
         for (int m = 0; m < NIN / 4; m++) begin
            {nxt[2*m], nxt[2*m+1]} = compress42(src[4*m], src[4*m+1],
                                                src[4*m+2], src[4*m+3]);
         end
      end

      always_ff @(posedge clk) begin
         if (!rst_n) begin
            for (int i = 0; i < NOUT; i++) begin
               q[i] <= '0;
            end
         end else if (rdy[j]) begin
            for (int i = 0; i < NOUT; i++) begin
               q[i] <= nxt[i];
            end
         end
      end
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         product_q <= '0;
      end else if (rdy[LEVELS]) begin
         product_q <= g_lvl[LEVELS-1].q[0] + g_lvl[LEVELS-1].q[1];
      end
   end

   assign in_ready    = rdy[0];
   assign out_valid   = v[LEVELS];
   assign out_product = product_q;
   assign out_tag     = tag_q[LEVELS];

endmodule
